// File: rtl/armish_seq_ctrl.sv
// Microinstruction sequencer for the ARMish datapath: fetch/decode/execute FSM
// with NZCV flag register, conditional branches, HALT and a per-run step limit.
module armish_seq_ctrl #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned MAX_STEPS = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      flags,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [23:0]     imem_rdata,
    output logic [2:0]      dp_op,
    output logic [4:0]      dp_sh,
    output logic [2:0]      dp_d,
    output logic [2:0]      dp_n,
    output logic [2:0]      dp_m,
    output logic            dp_dw,
    input  logic            dp_cn,
    input  logic            dp_cz,
    input  logic            dp_cc,
    input  logic            dp_cv
);

    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {CLS_ALU = 2'b00, CLS_CMP = 2'b01, CLS_BR = 2'b10, CLS_HALT = 2'b11} cls_t;

    state_t            state;
    cls_t              ir_cls;
    cls_t              fetch_cls;
    logic              ir_s;
    logic [2:0]        ir_cond;
    logic [PC_W-1:0]   ir_target;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_inc;
    logic [PC_W-1:0]   pc_inc;
    logic              cond_true;

    assign imem_addr = pc;
    assign fetch_cls = cls_t'(imem_rdata[23:22]);
    assign step_inc  = step + STEP_W'(1);
    assign pc_inc    = pc + PC_W'(1);

    // flags = {N,Z,C,V}
    always_comb begin
        cond_true = 1'b0;
        case (ir_cond)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = flags[2];
            3'd2: cond_true = !flags[2];
            3'd3: cond_true = flags[3];
            3'd4: cond_true = !flags[3];
            3'd5: cond_true = flags[1];
            3'd6: cond_true = !flags[1];
            3'd7: cond_true = flags[0];
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            flags     <= '0;
            ir_cls    <= CLS_ALU;
            ir_s      <= 1'b0;
            ir_cond   <= '0;
            ir_target <= '0;
            step      <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            imem_en   <= 1'b0;
            dp_op     <= '0;
            dp_sh     <= '0;
            dp_d      <= '0;
            dp_n      <= '0;
            dp_m      <= '0;
            dp_dw     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc      <= start_pc;
                        step    <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        imem_en <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    imem_en <= 1'b0;
                    state   <= S_DECODE;
                end
                S_DECODE: begin
                    // Datapath controls are registered straight from the ROM word so
                    // they are valid for the whole EXEC cycle.
                    ir_cls    <= fetch_cls;
                    ir_s      <= imem_rdata[21];
                    ir_cond   <= imem_rdata[21:19];
                    ir_target <= imem_rdata[PC_W-1:0];
                    if (fetch_cls == CLS_ALU || fetch_cls == CLS_CMP) begin
                        dp_op <= imem_rdata[20:18];
                        dp_d  <= imem_rdata[17:15];
                        dp_n  <= imem_rdata[14:12];
                        dp_m  <= imem_rdata[11:9];
                        dp_sh <= imem_rdata[8:4];
                        dp_dw <= (fetch_cls == CLS_ALU);
                    end
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    dp_op <= '0;
                    dp_sh <= '0;
                    dp_d  <= '0;
                    dp_n  <= '0;
                    dp_m  <= '0;
                    dp_dw <= 1'b0;
                    case (ir_cls)
                        CLS_ALU: begin
                            pc <= pc_inc;
                            if (ir_s)
                                flags <= {dp_cn, dp_cz, dp_cc, dp_cv};
                        end
                        CLS_CMP: begin
                            pc    <= pc_inc;
                            flags <= {dp_cn, dp_cz, dp_cc, dp_cv};
                        end
                        CLS_BR:   pc <= cond_true ? ir_target : pc_inc;
                        default: ;
                    endcase
                    if (ir_cls == CLS_HALT) begin
                        err   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        step <= step_inc;
                        if (step_inc == STEP_W'(MAX_STEPS)) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            imem_en <= 1'b1;
                            state   <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_armish_seq_ctrl.sv
// Bench for armish_seq_ctrl: synchronous ROM, stub ALU flags and an
// instruction-level reference interpreter compared at the end of each run.
module tb_armish_seq_ctrl;

    localparam int unsigned MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_pc = '0;
    logic        busy, done, err, imem_en, dp_dw;
    logic [7:0]  pc, imem_addr;
    logic [3:0]  flags;
    logic [23:0] imem_rdata = '0;
    logic [2:0]  dp_op, dp_d, dp_n, dp_m;
    logic [4:0]  dp_sh;
    logic        dp_cn, dp_cz, dp_cc, dp_cv;

    logic [23:0] rom [256];
    logic [3:0]  stub_mask = '0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fetch_q[$];
    logic [16:0] dw_q[$];
    logic [7:0]  exp_fetch[$];
    logic [16:0] exp_dw[$];
    logic [7:0]  exp_pc;
    logic        exp_err;
    logic [3:0]  m_flags = '0;

    armish_seq_ctrl #(.PC_W(8), .MAX_STEPS(MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .busy(busy), .done(done), .err(err), .pc(pc), .flags(flags),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dp_op(dp_op), .dp_sh(dp_sh), .dp_d(dp_d), .dp_n(dp_n), .dp_m(dp_m),
        .dp_dw(dp_dw), .dp_cn(dp_cn), .dp_cz(dp_cz), .dp_cc(dp_cc), .dp_cv(dp_cv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

    function automatic logic [3:0] stub_fn(input logic [2:0] op, input logic [4:0] sh,
                                           input logic [2:0] d, input logic [2:0] n,
                                           input logic [2:0] m);
        return {n[1] ^ m[2], d[0] ^ sh[4], op[1] ^ sh[0], n[0] ^ m[0]};
    endfunction

    assign {dp_cn, dp_cz, dp_cc, dp_cv} = stub_mask ^ stub_fn(dp_op, dp_sh, dp_d, dp_n, dp_m);

    always @(negedge clk) begin
        if (imem_en) fetch_q.push_back(imem_addr);
        if (dp_dw)   dw_q.push_back({dp_op, dp_sh, dp_d, dp_n, dp_m});
    end

    function automatic logic [23:0] enc_alu(input logic cmp, input logic s, input logic [2:0] op,
                                            input logic [2:0] d, input logic [2:0] n,
                                            input logic [2:0] m, input logic [4:0] sh);
        return {1'b0, cmp, s, op, d, n, m, sh, 4'b0};
    endfunction

    function automatic logic [23:0] enc_br(input logic [2:0] cond, input logic [7:0] target);
        return {2'b10, cond, 11'b0, target};
    endfunction

    localparam logic [23:0] HALT = {2'b11, 22'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Interprets the program one instruction at a time from the ROM contents.
    task automatic model_run(input logic [7:0] spc);
        logic [7:0]  p;
        logic [23:0] w;
        logic        take;
        int unsigned steps;
        exp_fetch.delete();
        exp_dw.delete();
        p = spc;
        steps = 0;
        exp_err = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp_fetch.push_back(p);
            w = rom[p];
            if (w[23:22] == 2'b11) break;
            if (w[23] == 1'b0) begin
                if (w[22] == 1'b0) exp_dw.push_back({w[20:18], w[8:4], w[17:15], w[14:12], w[11:9]});
                if (w[22] || w[21])
                    m_flags = stub_mask ^ stub_fn(w[20:18], w[8:4], w[17:15], w[14:12], w[11:9]);
                p = p + 8'd1;
            end else begin
                case (w[21:19])
                    3'd0: take = 1'b1;
                    3'd1: take = m_flags[2];
                    3'd2: take = !m_flags[2];
                    3'd3: take = m_flags[3];
                    3'd4: take = !m_flags[3];
                    3'd5: take = m_flags[1];
                    3'd6: take = !m_flags[1];
                    default: take = m_flags[0];
                endcase
                p = take ? w[7:0] : p + 8'd1;
            end
            steps++;
            if (steps == MAX) begin
                exp_err = 1'b1;
                break;
            end
        end
        exp_pc = p;
    endtask

    task automatic run_prog(input string tag, input logic [7:0] spc, input logic glitch);
        int cyc;
        int exp_cyc;
        model_run(spc);
        exp_cyc = 3 * exp_fetch.size() + 1;
        fetch_q.delete();
        dw_q.delete();
        @(negedge clk);
        start = 1'b1;
        start_pc = spc;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy_rise"}, busy, 1);
        while (!done && cyc < 200) begin
            if (glitch && cyc == 2) begin
                start = 1'b1;
                start_pc = spc + 8'h55;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, cyc, exp_cyc);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_flags"}, flags, m_flags);
        check({tag, "_nfetch"}, fetch_q.size(), exp_fetch.size());
        for (int i = 0; i < exp_fetch.size() && i < fetch_q.size(); i++)
            check({tag, "_fetch_addr"}, fetch_q[i], exp_fetch[i]);
        check({tag, "_ndw"}, dw_q.size(), exp_dw.size());
        for (int i = 0; i < exp_dw.size() && i < dw_q.size(); i++)
            check({tag, "_dw_ctl"}, dw_q[i], exp_dw[i]);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic check_zero(input string tag);
        check(tag, {busy, done, err, pc, imem_addr, flags, imem_en,
                    dp_op, dp_sh, dp_d, dp_n, dp_m, dp_dw}, 0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 256; i++) rom[i] = HALT;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;

        rom[8'h10] = enc_alu(1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 3'd3, 5'd0);
        rom[8'h11] = HALT;
        run_prog("t1_alu", 8'h10, 1'b0);
        check("t1_dw_d", dw_q.size() == 1 ? {29'b0, dw_q[0][8:6]} : 32'hFFFF, 1);

        rom[8'h20] = enc_alu(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 5'd0);
        rom[8'h21] = enc_br(3'd1, 8'h40);
        rom[8'h22] = HALT;
        rom[8'h40] = HALT;
        stub_mask = 4'b0100;
        run_prog("t2_beq_taken", 8'h20, 1'b1);
        check("t2_pc_target", pc, 8'h40);
        check("t2_flags", flags, 4'b0100);

        stub_mask = 4'b0000;
        run_prog("t3_beq_not", 8'h20, 1'b0);
        check("t3_last_fetch", fetch_q.size() > 0 ? fetch_q[fetch_q.size()-1] : 8'h0, 8'h22);

        rom[8'hFF] = enc_alu(1'b0, 1'b1, 3'd2, 3'd5, 3'd6, 3'd7, 5'd3);
        rom[8'h00] = HALT;
        stub_mask = 4'b1010;
        run_prog("t4_wrap", 8'hFF, 1'b0);
        check("t4_pc_wrapped", pc, 8'h00);

        rom[8'h00] = enc_br(3'd0, 8'h00);
        run_prog("t5_maxsteps", 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("t5_err_held", err, 1);
        rom[8'h00] = HALT;

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);
            stub_mask = 4'($urandom);
            run_prog("rand", 8'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 256; i++) rom[i] = HALT;
        rom[8'h30] = enc_alu(1'b0, 1'b1, 3'd1, 3'd2, 3'd3, 3'd4, 5'd17);
        stub_mask = 4'b1111;
        @(negedge clk);
        start = 1'b1;
        start_pc = 8'h30;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (dp_dw) seen = 1;
            else @(negedge clk);
        end
        check("t6_exec_reached", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_flags = '0;
        check_zero("t6_after_reset");
        @(negedge clk);
        check_zero("t6_stays_idle");

        stub_mask = 4'b0000;
        rom[8'h10] = enc_alu(1'b0, 1'b0, 3'd0, 3'd1, 3'd2, 3'd3, 5'd0);
        rom[8'h11] = HALT;
        run_prog("t7_recover", 8'h10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
